vc_rr_arbiter: RTL and testbench

VC_RR_ARBITER -- requirements
Module: vc_rr_arbiter

---
 rtl/vc_arb_pkg.sv | 10 +
 rtl/rr_picker.sv | 27 ++
 rtl/vc_rr_arbiter.sv | 77 +++++++
 tb/tb_vc_rr_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: shared state encoding and width helpers for the credit-link arbiter
package vc_arb_pkg;
    typedef enum logic {IDLE, LOCK} state_t;
    function automatic int cnt_w(input int credits);
        return $clog2(credits + 1);
    endfunction
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder starting at rr_ptr
module rr_picker
    import vc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [id_w(NUM_REQ)-1:0]  rr_ptr,
    output logic [id_w(NUM_REQ)-1:0]  winner,
    output logic                      any_valid
);
    localparam int IW = id_w(NUM_REQ);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;
    // rotate so rr_ptr lands at bit 0, then take the lowest set bit
    assign dbl = {req_valid, req_valid} >> rr_ptr;
    assign rot = dbl[NUM_REQ-1:0];
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    end
    assign sum       = {1'b0, rr_ptr} + {1'b0, off};
    assign winner    = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
    assign any_valid = |req_valid;
endmodule

// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: round-robin burst arbiter feeding a credit-flow-controlled link
module vc_rr_arbiter
    import vc_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int CREDITS   = 7,
    parameter int MAX_BURST = 4
)(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_valid,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        credit_in,
    output logic [cnt_w(CREDITS)-1:0]   credits_avail,
    output logic [id_w(NUM_REQ)-1:0]    grant_id,
    output logic                        busy,
    output logic                        credit_err
);
    localparam int IW = id_w(NUM_REQ);
    localparam int CW = cnt_w(CREDITS);
    localparam int BW = $clog2(MAX_BURST + 1);
    state_t            state;
    logic [IW-1:0]     owner, rr_ptr, winner;
    logic [BW-1:0]     beat_cnt;
    logic              any_valid, ready_en, xfer, last_beat;
    logic [DATA_W-1:0] owner_data;
    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );
    assign ready_en  = (state == LOCK) && (credits_avail != '0);
    assign req_ready = ready_en ? (NUM_REQ'(1) << owner) : '0;
    assign xfer      = ready_en && req_valid[owner];
    assign last_beat = beat_cnt == BW'(MAX_BURST - 1);
    assign grant_id  = owner;
    assign busy      = state == LOCK;
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) owner_data = (owner == IW'(i)) ? req_data[i*DATA_W +: DATA_W] : owner_data;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            beat_cnt      <= '0;
            credits_avail <= CW'(CREDITS);
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            credit_err    <= 1'b0;
        end else begin
            tx_valid <= xfer;
            if (xfer) tx_data <= owner_data;
            if (xfer && !credit_in) credits_avail <= credits_avail - 1'b1;
            else if (!xfer && credit_in) begin
                if (credits_avail == CW'(CREDITS)) credit_err <= 1'b1;
                else credits_avail <= credits_avail + 1'b1;
            end
            if (state == IDLE) begin
                if (any_valid) begin
                    state    <= LOCK;
                    owner    <= winner;
                    beat_cnt <= '0;
                end
            end else if (!req_valid[owner] || (xfer && last_beat)) begin
                state  <= IDLE;
                rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end else if (xfer) beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb_vc_rr_arbiter: directed table-driven and sequence checks for vc_rr_arbiter
module tb_vc_rr_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        credit_in;
    logic [2:0]  credits_avail;
    logic [1:0]  grant_id;
    logic        busy;
    logic        credit_err;
    int passed = 0;
    int total  = 0;
    logic [3:0] pend;
    logic       echo;
    typedef struct {
        logic [3:0] rv;
        logic       ci;
        logic       tv;
        logic [7:0] td;
        logic       bz;
        logic [1:0] gid;
        logic [3:0] rdy;
        logic [2:0] cr;
        logic       err;
    } vec_t;
    vec_t vt[16];
    int eg[5];
    vc_rr_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .credit_in     (credit_in),
        .credits_avail (credits_avail),
        .grant_id      (grant_id),
        .busy          (busy),
        .credit_err    (credit_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        pend = {pend[2:0], tx_valid};
        if (echo) credit_in = pend[3];
    endtask
    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        credit_in = 1'b0;
        echo      = 1'b0;
        pend      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask
    initial begin
        int beats, ng, nf, idle;
        logic pb;
        logic hit;
        req_data = 32'h44332211;
        do_reset();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_credits", credits_avail, 7);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", credit_err, 0);
        check("rst_ready", req_ready, 0);
        vt[0]  = '{4'b1010, 1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 4'b0010, 3'd7, 1'b0};
        vt[1]  = '{4'b1010, 1'b0, 1'b1, 8'h22, 1'b1, 2'd1, 4'b0010, 3'd6, 1'b0};
        vt[2]  = '{4'b1010, 1'b0, 1'b1, 8'h22, 1'b1, 2'd1, 4'b0010, 3'd5, 1'b0};
        vt[3]  = '{4'b1000, 1'b0, 1'b0, 8'h22, 1'b0, 2'd1, 4'b0000, 3'd5, 1'b0};
        vt[4]  = '{4'b1000, 1'b0, 1'b0, 8'h22, 1'b1, 2'd3, 4'b1000, 3'd5, 1'b0};
        vt[5]  = '{4'b1000, 1'b0, 1'b1, 8'h44, 1'b1, 2'd3, 4'b1000, 3'd4, 1'b0};
        vt[6]  = '{4'b1000, 1'b0, 1'b1, 8'h44, 1'b1, 2'd3, 4'b1000, 3'd3, 1'b0};
        vt[7]  = '{4'b1000, 1'b1, 1'b1, 8'h44, 1'b1, 2'd3, 4'b1000, 3'd3, 1'b0};
        vt[8]  = '{4'b1000, 1'b0, 1'b1, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd2, 1'b0};
        vt[9]  = '{4'b0000, 1'b1, 1'b0, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd3, 1'b0};
        vt[10] = '{4'b0000, 1'b1, 1'b0, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd4, 1'b0};
        vt[11] = '{4'b0000, 1'b1, 1'b0, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd5, 1'b0};
        vt[12] = '{4'b0000, 1'b1, 1'b0, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd6, 1'b0};
        vt[13] = '{4'b0000, 1'b1, 1'b0, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd7, 1'b0};
        vt[14] = '{4'b0000, 1'b1, 1'b0, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd7, 1'b1};
        vt[15] = '{4'b0000, 1'b0, 1'b0, 8'h44, 1'b0, 2'd3, 4'b0000, 3'd7, 1'b1};
        for (int i = 0; i < 16; i++) begin
            req_valid = vt[i].rv;
            credit_in = vt[i].ci;
            tick();
            check($sformatf("v%0d_tx_valid", i), tx_valid, vt[i].tv);
            check($sformatf("v%0d_tx_data", i), tx_data, vt[i].td);
            check($sformatf("v%0d_busy", i), busy, vt[i].bz);
            check($sformatf("v%0d_grant_id", i), grant_id, vt[i].gid);
            check($sformatf("v%0d_ready", i), req_ready, vt[i].rdy);
            check($sformatf("v%0d_credits", i), credits_avail, vt[i].cr);
            check($sformatf("v%0d_err", i), credit_err, vt[i].err);
        end
        credit_in = 1'b0;
        req_valid = 4'b0100;
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            tick();
            hit = credits_avail == 3'd2;
        end
        check("mid_reached_cr2", hit, 1);
        check("mid_busy", busy, 1);
        check("mid_err_sticky", credit_err, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_tx_valid", tx_valid, 0);
        check("async_tx_data", tx_data, 0);
        check("async_busy", busy, 0);
        check("async_credits", credits_avail, 7);
        check("async_grant_id", grant_id, 0);
        check("async_ready", req_ready, 0);
        check("async_err", credit_err, 0);
        #2 reset_n = 1'b1;
        req_valid = 4'b1111;
        tick();
        check("post_rst_busy", busy, 1);
        check("post_rst_grant", grant_id, 0);
        tick();
        check("post_rst_tx_valid", tx_valid, 1);
        check("post_rst_tx_data", tx_data, 8'h11);
        do_reset();
        req_valid = 4'b0100;
        beats = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (tx_valid) beats++;
        end
        check("starve_beats", beats, 7);
        check("starve_credits", credits_avail, 0);
        check("starve_ready", req_ready, 0);
        check("starve_busy", busy, 1);
        check("starve_grant", grant_id, 2);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        beats = tx_valid ? 1 : 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (tx_valid) beats++;
        end
        check("one_credit_beats", beats, 1);
        do_reset();
        eg = '{0, 1, 2, 3, 0};
        echo = 1'b1;
        req_valid = 4'b1111;
        pb = 1'b0; ng = 0; nf = 0; beats = 0; idle = 0;
        for (int c = 0; c < 200 && nf < 5; c++) begin
            tick();
            if (tx_valid) beats++;
            if (busy && !pb) begin
                if (ng < 5) check($sformatf("rr_grant%0d", ng), grant_id, eg[ng]);
                if (ng > 0) check($sformatf("rr_idle%0d", ng), idle, 1);
                ng++;
            end
            if (!busy && pb) begin
                check($sformatf("rr_burst%0d", nf), beats, 4);
                beats = 0;
                nf++;
                idle = 1;
            end else if (!busy) idle++;
            pb = busy;
        end
        check("rr_bursts_done", nf, 5);
        echo = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
